// File: rtl/recorder_ingress_buffer.sv
// Ingress buffer for the memory recorder: captures strobed audio samples into a
// FIFO, bounds each take to a programmed length and streams samples downstream.
module recorder_ingress_buffer #(
  parameter int RECORD_BIT_WIDTH_P = 16,
  parameter int FIFO_DEPTH_P       = 16,
  parameter int COUNTER_WIDTH_P    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [RECORD_BIT_WIDTH_P-1:0] smp_data,
  input  logic                          smp_valid,
  input  logic                          cr_record_start,
  input  logic                          cr_record_stop,
  input  logic [COUNTER_WIDTH_P-1:0]    cr_record_length,
  output logic [RECORD_BIT_WIDTH_P-1:0] ing_tdata,
  output logic                          ing_tvalid,
  input  logic                          ing_tready,
  output logic                          sr_busy,
  output logic [COUNTER_WIDTH_P-1:0]    sr_recorded_count,
  output logic [COUNTER_WIDTH_P-1:0]    sr_overflow_count,
  output logic                          irq_record_done,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH_P);
  localparam logic [AW:0]                 PTR_ONE = 1;
  localparam logic [COUNTER_WIDTH_P-1:0]  CNT_ONE = 1;
  localparam logic [COUNTER_WIDTH_P-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [RECORD_BIT_WIDTH_P-1:0] mem [FIFO_DEPTH_P];
  logic [AW:0]                   wr_ptr, rd_ptr;
  logic                          full, empty, push, pop;

  logic [COUNTER_WIDTH_P-1:0] length_q, recorded_q, overflow_q;
  logic                       clear_cnt, load_len, rec_inc, ovf_inc;
  logic                       irq_q, irq_next;

  // Stream handshake: a sample transfers on every cycle where ing_tvalid and
  // ing_tready are both high; ing_tvalid never drops and ing_tdata never changes
  // while a sample is offered and not yet accepted.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !empty && ing_tready;
  assign ing_tvalid = !empty;
  assign ing_tdata  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH_P; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= smp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // push is only raised when not full, so a same-cycle pop never rescues a strobe.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    clear_cnt  = 1'b0;
    load_len   = 1'b0;
    rec_inc    = 1'b0;
    ovf_inc    = 1'b0;
    irq_next   = 1'b0;
    case (state)
      IDLE: begin
        if (cr_record_start) begin
          clear_cnt  = 1'b1;
          load_len   = 1'b1;
          state_next = (cr_record_length == '0) ? DRAIN : RECORD;
        end
      end
      RECORD: begin
        if (cr_record_stop) begin
          state_next = DRAIN;
        end else if (smp_valid) begin
          if (!full) begin
            push    = 1'b1;
            rec_inc = 1'b1;
            if ((recorded_q + CNT_ONE) == length_q) state_next = DRAIN;
          end else begin
            ovf_inc = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (empty) begin
          irq_next   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      length_q   <= '0;
      recorded_q <= '0;
      overflow_q <= '0;
    end else begin
      if (load_len) length_q <= cr_record_length;
      if (clear_cnt) begin
        recorded_q <= '0;
        overflow_q <= '0;
      end else begin
        if (rec_inc) recorded_q <= recorded_q + CNT_ONE;
        if (ovf_inc && (overflow_q != CNT_MAX)) overflow_q <= overflow_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_next;
  end

  assign sr_busy           = (state != IDLE);
  assign sr_recorded_count = recorded_q;
  assign sr_overflow_count = overflow_q;
  assign irq_record_done   = irq_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_recorder_ingress_buffer.sv
// Randomised bench for recorder_ingress_buffer: a take-level reference model
// feeds an expected-sample queue that a negedge monitor drains and checks.
module tb_recorder_ingress_buffer;

  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int CW    = 32;

  localparam int M_IDLE = 0;
  localparam int M_REC  = 1;
  localparam int M_DRN  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  smp_data;
  logic          smp_valid;
  logic          cr_record_start;
  logic          cr_record_stop;
  logic [CW-1:0] cr_record_length;
  logic [W-1:0]  ing_tdata;
  logic          ing_tvalid;
  logic          ing_tready;
  logic          sr_busy;
  logic [CW-1:0] sr_recorded_count;
  logic [CW-1:0] sr_overflow_count;
  logic          irq_record_done;
  logic [1:0]    dbg_state;

  recorder_ingress_buffer #(
    .RECORD_BIT_WIDTH_P(W),
    .FIFO_DEPTH_P(DEPTH),
    .COUNTER_WIDTH_P(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .smp_data(smp_data),
    .smp_valid(smp_valid),
    .cr_record_start(cr_record_start),
    .cr_record_stop(cr_record_stop),
    .cr_record_length(cr_record_length),
    .ing_tdata(ing_tdata),
    .ing_tvalid(ing_tvalid),
    .ing_tready(ing_tready),
    .sr_busy(sr_busy),
    .sr_recorded_count(sr_recorded_count),
    .sr_overflow_count(sr_overflow_count),
    .irq_record_done(irq_record_done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  int            n_irq  = 0;

  // reference model of the take: mode, buffered count, counters, irq
  int            m_mode = M_IDLE;
  int            m_occ  = 0;
  logic [CW-1:0] m_len  = '0;
  logic [CW-1:0] m_rec  = '0;
  logic [CW-1:0] m_ovf  = '0;
  logic          m_irq  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_mode = M_IDLE;
    m_occ  = 0;
    m_len  = '0;
    m_rec  = '0;
    m_ovf  = '0;
    m_irq  = 1'b0;
    exp_q.delete();
  endtask

  // Evaluated at each rising edge with the inputs the DUT is sampling.
  task automatic model_update();
    int pushed;
    int popped;
    if (!rst_n) begin
      model_clear();
      return;
    end
    popped = (m_occ > 0 && ing_tready) ? 1 : 0;
    pushed = 0;
    m_irq  = 1'b0;
    if (m_mode == M_IDLE) begin
      if (cr_record_start) begin
        m_len  = cr_record_length;
        m_rec  = '0;
        m_ovf  = '0;
        m_mode = (cr_record_length == 0) ? M_DRN : M_REC;
      end
    end else if (m_mode == M_REC) begin
      if (cr_record_stop) begin
        m_mode = M_DRN;
      end else if (smp_valid) begin
        if (m_occ < DEPTH) begin
          pushed = 1;
          exp_q.push_back(smp_data);
          m_rec = m_rec + 1;
          if (m_rec == m_len) m_mode = M_DRN;
        end else if (m_ovf != {CW{1'b1}}) begin
          m_ovf = m_ovf + 1;
        end
      end
    end else begin
      if (m_occ == 0) begin
        m_irq  = 1'b1;
        m_mode = M_IDLE;
      end
    end
    m_occ = m_occ + pushed - popped;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("busy", sr_busy, (m_mode != M_IDLE));
    chk("recorded", sr_recorded_count, m_rec);
    chk("overflow", sr_overflow_count, m_ovf);
    chk("irq", irq_record_done, m_irq);
    chk("tvalid", ing_tvalid, (exp_q.size() > 0));
    if (irq_record_done) n_irq++;
    if (exp_q.size() > 0 && ing_tvalid) begin
      chk("tdata", ing_tdata, exp_q[0]);
      if (ing_tready) void'(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    smp_valid       = 1'b0;
    cr_record_start = 1'b0;
    cr_record_stop  = 1'b0;
  endtask

  task automatic start_take(input logic [CW-1:0] len);
    cr_record_start  = 1'b1;
    cr_record_length = len;
    cycle();
  endtask

  task automatic strobe();
    smp_valid = 1'b1;
    smp_data  = W'($urandom);
    cycle();
  endtask

  task automatic stop_take();
    cr_record_stop = 1'b1;
    cycle();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    ing_tready = 1'b1;
    while (sr_busy && n < budget) begin
      cycle();
      n++;
    end
    if (sr_busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_tdata", ing_tdata, '0);
    chk("rst_tvalid", ing_tvalid, 1'b0);
    chk("rst_busy", sr_busy, 1'b0);
    chk("rst_rec", sr_recorded_count, '0);
    chk("rst_ovf", sr_overflow_count, '0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic take_of_eight();
    int irq0;
    ing_tready = 1'b1;
    start_take(8);
    irq0 = n_irq;
    for (int i = 0; i < 8; i++) begin
      strobe();
      repeat (3) cycle();
    end
    wait_idle(50);
    cycle();
    chk("t8_rec", sr_recorded_count, 8);
    chk("t8_ovf", sr_overflow_count, 0);
    chk("t8_irqs", n_irq - irq0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n            = 1'b0;
    smp_data         = '0;
    smp_valid        = 1'b0;
    cr_record_start  = 1'b0;
    cr_record_stop   = 1'b0;
    cr_record_length = '0;
    ing_tready       = 1'b0;
    repeat (3) cycle();
    chk("rst0_tdata", ing_tdata, '0);
    rst_n = 1'b1;
    cycle();

    // strobes in IDLE are ignored
    repeat (3) strobe();
    chk("idle_rec", sr_recorded_count, 0);

    // length 8, slow strobes, always ready
    take_of_eight();

    // overfill: 20 strobes into a 16-deep FIFO with no consumer
    ing_tready = 1'b0;
    start_take(20);
    for (int i = 0; i < 20; i++) strobe();
    chk("of_ovf", sr_overflow_count, 4);
    chk("of_rec", sr_recorded_count, 16);
    chk("of_busy", sr_busy, 1'b1);
    ing_tready = 1'b1;
    repeat (20) cycle();
    stop_take();
    wait_idle(50);

    // zero-length take: done pulse two edges after start, no data
    ing_tready = 1'b1;
    start_take(0);
    chk("z_irq_early", irq_record_done, 1'b0);
    cycle();
    chk("z_irq", irq_record_done, 1'b1);
    chk("z_busy", sr_busy, 1'b0);
    cycle();

    // abort with three samples still buffered; the stop-cycle strobe is dropped
    ing_tready = 1'b0;
    start_take(100);
    for (int i = 0; i < 5; i++) strobe();
    ing_tready = 1'b1;
    cycle();
    cycle();
    ing_tready = 1'b0;
    smp_valid = 1'b1;
    smp_data  = W'($urandom);
    stop_take();
    chk("ab_rec", sr_recorded_count, 5);
    ing_tready = 1'b1;
    for (int i = 0; i < 4; i++) strobe();
    wait_idle(50);
    chk("ab_rec_end", sr_recorded_count, 5);
    chk("ab_ovf_end", sr_overflow_count, 0);

    // full FIFO: pop and strobe in the same cycle still drops the strobe
    ing_tready = 1'b0;
    start_take(40);
    for (int i = 0; i < DEPTH; i++) strobe();
    ing_tready = 1'b1;
    strobe();
    chk("fp_ovf", sr_overflow_count, 1);
    chk("fp_rec", sr_recorded_count, DEPTH);
    chk("fp_tvalid", ing_tvalid, 1'b1);
    ing_tready = 1'b0;
    stop_take();
    wait_idle(50);

    // reset in the middle of a take, then a normal take
    ing_tready = 1'b0;
    start_take(30);
    for (int i = 0; i < 6; i++) strobe();
    do_reset();
    chk("rr_busy", sr_busy, 1'b0);
    take_of_eight();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      ing_tready       = ($urandom_range(0, 9) < 7);
      cr_record_length = CW'($urandom_range(0, 24));
      cr_record_start  = ($urandom_range(0, 39) == 0);
      cr_record_stop   = ($urandom_range(0, 79) == 0);
      smp_valid        = $urandom_range(0, 1);
      smp_data         = W'($urandom);
      cycle();
    end
    if (sr_busy) begin
      stop_take();
      wait_idle(100);
    end
    cycle();
    chk("final_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
